// File: rtl/rs_cdb_snoop.sv
// Reservation station for one functional unit. It snoops the common data bus for
// waiting operands and dispatches operand-complete entries, lowest index first.
module rs_cdb_snoop #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int OP_W  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ISSUE_VALID,
  output logic                    ISSUE_READY,
  input  logic [OP_W-1:0]         ISSUE_OP,
  input  logic [TAG_W-1:0]        ISSUE_DEST_TAG,
  input  logic [TAG_W-1:0]        ISSUE_Q1,
  input  logic [31:0]             ISSUE_V1,
  input  logic [TAG_W-1:0]        ISSUE_Q2,
  input  logic [31:0]             ISSUE_V2,
  input  logic [TAG_W-1:0]        CDB_TAG,
  input  logic [31:0]             CDB_DATA,
  output logic                    DISP_VALID,
  input  logic                    DISP_READY,
  output logic [OP_W-1:0]         DISP_OP,
  output logic [31:0]             DISP_A,
  output logic [31:0]             DISP_B,
  output logic [TAG_W-1:0]        DISP_TAG,
  output logic [$clog2(DEPTH):0]  COUNT
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] busy_r;
  logic [OP_W-1:0]  op_r   [DEPTH];
  logic [TAG_W-1:0] dest_r [DEPTH];
  logic [TAG_W-1:0] q1_r   [DEPTH];
  logic [31:0]      v1_r   [DEPTH];
  logic [TAG_W-1:0] q2_r   [DEPTH];
  logic [31:0]      v2_r   [DEPTH];
  logic [CNT_W-1:0] count_r;

  logic [DEPTH-1:0] ready_s;
  logic [IDX_W-1:0] free_idx_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             any_ready_s;
  logic             issue_fire_s;
  logic             disp_fire_s;
  logic             cdb_hit_s;

  assign cdb_hit_s    = (CDB_TAG != {TAG_W{1'b0}});
  assign ISSUE_READY  = (count_r < CNT_W'(DEPTH));
  assign issue_fire_s = ISSUE_VALID && ISSUE_READY;
  assign disp_fire_s  = any_ready_s && DISP_READY;
  assign COUNT        = count_r;

  // Priority scan: descending loop leaves the lowest free and lowest ready index
  always_comb begin
    ready_s     = {DEPTH{1'b0}};
    free_idx_s  = {IDX_W{1'b0}};
    sel_idx_s   = {IDX_W{1'b0}};
    any_ready_s = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready_s[i] = busy_r[i] && (q1_r[i] == {TAG_W{1'b0}}) && (q2_r[i] == {TAG_W{1'b0}});
      if (!busy_r[i]) begin
        free_idx_s = IDX_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
      if (ready_s[i]) begin
        sel_idx_s   = IDX_W'(i);
        any_ready_s = 1'b1;
      end else begin
        sel_idx_s   = sel_idx_s;
        any_ready_s = any_ready_s;
      end
    end
  end

  // Dispatch port driven straight from the selected entry, zero when idle
  always_comb begin
    DISP_VALID = any_ready_s;
    DISP_OP    = {OP_W{1'b0}};
    DISP_A     = 32'h0000_0000;
    DISP_B     = 32'h0000_0000;
    DISP_TAG   = {TAG_W{1'b0}};
    if (any_ready_s) begin
      DISP_OP  = op_r[sel_idx_s];
      DISP_A   = v1_r[sel_idx_s];
      DISP_B   = v2_r[sel_idx_s];
      DISP_TAG = dest_r[sel_idx_s];
    end else begin
      DISP_OP  = {OP_W{1'b0}};
    end
  end

  // Entry storage: issue write with same-cycle forwarding, CDB capture, dispatch release
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        op_r[i]   <= {OP_W{1'b0}};
        dest_r[i] <= {TAG_W{1'b0}};
        q1_r[i]   <= {TAG_W{1'b0}};
        v1_r[i]   <= 32'h0000_0000;
        q2_r[i]   <= {TAG_W{1'b0}};
        v2_r[i]   <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_fire_s && (free_idx_s == IDX_W'(i))) begin
          busy_r[i] <= 1'b1;
          op_r[i]   <= ISSUE_OP;
          dest_r[i] <= ISSUE_DEST_TAG;
          if (cdb_hit_s && (CDB_TAG == ISSUE_Q1)) begin
            q1_r[i] <= {TAG_W{1'b0}};
            v1_r[i] <= CDB_DATA;
          end else begin
            q1_r[i] <= ISSUE_Q1;
            v1_r[i] <= ISSUE_V1;
          end
          if (cdb_hit_s && (CDB_TAG == ISSUE_Q2)) begin
            q2_r[i] <= {TAG_W{1'b0}};
            v2_r[i] <= CDB_DATA;
          end else begin
            q2_r[i] <= ISSUE_Q2;
            v2_r[i] <= ISSUE_V2;
          end
        end else begin
          if (disp_fire_s && (sel_idx_s == IDX_W'(i))) begin
            busy_r[i] <= 1'b0;
          end
          // A dispatching entry has q1 = q2 = 0, so it can never match here
          if (busy_r[i] && cdb_hit_s && (q1_r[i] == CDB_TAG)) begin
            q1_r[i] <= {TAG_W{1'b0}};
            v1_r[i] <= CDB_DATA;
          end
          if (busy_r[i] && cdb_hit_s && (q2_r[i] == CDB_TAG)) begin
            q2_r[i] <= {TAG_W{1'b0}};
            v2_r[i] <= CDB_DATA;
          end
        end
      end
    end
  end

  // Occupancy counter; issue is gated by ISSUE_READY so it stops exactly at DEPTH
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({issue_fire_s, disp_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_cdb_snoop.sv
// Bench for rs_cdb_snoop: a vector table plus hand sequences; every dispatch handshake
// is checked against a queue of expected results filled as instructions are issued.
module tb_rs_cdb_snoop;

  logic        CLK, RST;
  logic        ISSUE_VALID, ISSUE_READY;
  logic [3:0]  ISSUE_OP, ISSUE_DEST_TAG, ISSUE_Q1, ISSUE_Q2;
  logic [31:0] ISSUE_V1, ISSUE_V2;
  logic [3:0]  CDB_TAG;
  logic [31:0] CDB_DATA;
  logic        DISP_VALID, DISP_READY;
  logic [3:0]  DISP_OP, DISP_TAG;
  logic [31:0] DISP_A, DISP_B;
  logic [2:0]  COUNT;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic iv; logic acc;
    logic [3:0] op; logic [3:0] dest; logic [3:0] q1; logic [31:0] v1;
    logic [3:0] q2; logic [31:0] v2;
    logic [3:0] ctag; logic [31:0] cdata; logic drdy;
    logic [2:0] cnt; logic irdy; logic dv;
    logic [31:0] da; logic [31:0] db; logic [3:0] dt;
    logic [31:0] fa; logic [31:0] fb;
  } vec_t;

  typedef struct {
    logic [3:0] op; logic [3:0] tag; logic [31:0] a; logic [31:0] b;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  sb_t  mon_e;

  rs_cdb_snoop #(.DEPTH(4), .TAG_W(4), .OP_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY), .ISSUE_OP(ISSUE_OP),
    .ISSUE_DEST_TAG(ISSUE_DEST_TAG), .ISSUE_Q1(ISSUE_Q1), .ISSUE_V1(ISSUE_V1),
    .ISSUE_Q2(ISSUE_Q2), .ISSUE_V2(ISSUE_V2), .CDB_TAG(CDB_TAG), .CDB_DATA(CDB_DATA),
    .DISP_VALID(DISP_VALID), .DISP_READY(DISP_READY), .DISP_OP(DISP_OP),
    .DISP_A(DISP_A), .DISP_B(DISP_B), .DISP_TAG(DISP_TAG), .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic outs(input string nm, input logic [2:0] cnt, input logic irdy, input logic dv,
                      input logic [31:0] da, input logic [31:0] db, input logic [3:0] dt);
    chk({nm, "_count"}, 32'(COUNT), 32'(cnt));
    chk({nm, "_irdy"},  32'(ISSUE_READY), 32'(irdy));
    chk({nm, "_dvalid"}, 32'(DISP_VALID), 32'(dv));
    chk({nm, "_da"}, DISP_A, da);
    chk({nm, "_db"}, DISP_B, db);
    chk({nm, "_dtag"}, 32'(DISP_TAG), 32'(dt));
  endtask

  task automatic cyc(input logic iv, input logic [3:0] op, input logic [3:0] dest,
                     input logic [3:0] q1, input logic [31:0] v1, input logic [3:0] q2,
                     input logic [31:0] v2, input logic [3:0] ctag, input logic [31:0] cdata,
                     input logic drdy);
    ISSUE_VALID = iv; ISSUE_OP = op; ISSUE_DEST_TAG = dest;
    ISSUE_Q1 = q1; ISSUE_V1 = v1; ISSUE_Q2 = q2; ISSUE_V2 = v2;
    CDB_TAG = ctag; CDB_DATA = cdata; DISP_READY = drdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic iv, input logic acc, input logic [3:0] op, input logic [3:0] dest,
                     input logic [3:0] q1, input logic [31:0] v1, input logic [3:0] q2,
                     input logic [31:0] v2, input logic [3:0] ctag, input logic [31:0] cd,
                     input logic drdy, input logic [2:0] cnt, input logic irdy, input logic dv,
                     input logic [31:0] da, input logic [31:0] db, input logic [3:0] dt,
                     input logic [31:0] fa, input logic [31:0] fb);
    vec_t v;
    v = '{iv, acc, op, dest, q1, v1, q2, v2, ctag, cd, drdy, cnt, irdy, dv, da, db, dt, fa, fb};
    tbl.push_back(v);
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] tag, input logic [31:0] a,
                      input logic [31:0] b);
    sb_t e;
    e = '{op, tag, a, b};
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: a handshake seen mid-cycle fires at the coming edge
  always @(negedge CLK) begin
    if (!RST && DISP_VALID && DISP_READY) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_op",  32'(DISP_OP),  32'(mon_e.op));
        chk("sb_tag", 32'(DISP_TAG), 32'(mon_e.tag));
        chk("sb_a",   DISP_A, mon_e.a);
        chk("sb_b",   DISP_B, mon_e.b);
      end
    end
  end

  initial begin
    RST = 1'b1;
    ISSUE_VALID = 1'b0; ISSUE_OP = 4'h0; ISSUE_DEST_TAG = 4'h0;
    ISSUE_Q1 = 4'h0; ISSUE_V1 = 32'h0; ISSUE_Q2 = 4'h0; ISSUE_V2 = 32'h0;
    CDB_TAG = 4'h0; CDB_DATA = 32'h0; DISP_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    outs("reset", 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("reset_dop", 32'(DISP_OP), 32'h0);
    RST = 1'b0;

    // Complete issue, CDB_TAG=0 with data must not disturb, then dispatch
    add(1'b1,1'b1,4'h1,4'h3,4'h0,32'h5,4'h0,32'h7, 4'h0,32'h0,1'b0, 3'd1,1'b1,1'b1,32'h5,32'h7,4'h3, 32'h5,32'h7);
    add(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,32'h0, 4'h0,32'hFFFF_FFFF,1'b0, 3'd1,1'b1,1'b1,32'h5,32'h7,4'h3, 32'h0,32'h0);
    add(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,32'h0, 4'h0,32'h0,1'b1, 3'd0,1'b1,1'b0,32'h0,32'h0,4'h0, 32'h0,32'h0);
    // Capture: wrong tag ignored, matching tag completes the entry
    add(1'b1,1'b1,4'h2,4'h7,4'h6,32'h123,4'h0,32'h9, 4'h0,32'h0,1'b0, 3'd1,1'b1,1'b0,32'h0,32'h0,4'h0, 32'hDEAD,32'h9);
    add(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,32'h0, 4'h5,32'hBEEF,1'b0, 3'd1,1'b1,1'b0,32'h0,32'h0,4'h0, 32'h0,32'h0);
    add(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,32'h0, 4'h6,32'hDEAD,1'b0, 3'd1,1'b1,1'b1,32'hDEAD,32'h9,4'h7, 32'h0,32'h0);
    add(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,32'h0, 4'h0,32'h0,1'b1, 3'd0,1'b1,1'b0,32'h0,32'h0,4'h0, 32'h0,32'h0);
    // Issue-cycle forwarding into both operands
    add(1'b1,1'b1,4'h3,4'h8,4'h4,32'hAAAA,4'h4,32'hBBBB, 4'h4,32'h11,1'b0, 3'd1,1'b1,1'b1,32'h11,32'h11,4'h8, 32'h11,32'h11);
    add(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,32'h0, 4'h0,32'h0,1'b1, 3'd0,1'b1,1'b0,32'h0,32'h0,4'h0, 32'h0,32'h0);
    // Fill to DEPTH, reject a fifth issue, then drain in index order
    for (int k = 0; k < 4; k++)
      add(1'b1,1'b1,4'(4+k),4'(9+k),4'h2,32'h0,4'h0,32'(10+k), 4'h0,32'h0,1'b0,
          3'(k+1),(k < 3),1'b0,32'h0,32'h0,4'h0, 32'h2222,32'(10+k));
    add(1'b1,1'b0,4'hF,4'hD,4'h0,32'h1,4'h0,32'h1, 4'h0,32'h0,1'b0, 3'd4,1'b0,1'b0,32'h0,32'h0,4'h0, 32'h0,32'h0);
    add(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,32'h0, 4'h2,32'h2222,1'b1, 3'd4,1'b0,1'b1,32'h2222,32'hA,4'h9, 32'h0,32'h0);
    for (int k = 0; k < 3; k++)
      add(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,32'h0, 4'h0,32'h0,1'b1,
          3'(3-k),1'b1,1'b1,32'h2222,32'(11+k),4'(10+k), 32'h0,32'h0);
    add(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,32'h0, 4'h0,32'h0,1'b1, 3'd0,1'b1,1'b0,32'h0,32'h0,4'h0, 32'h0,32'h0);

    foreach (tbl[k]) begin
      if (tbl[k].iv && tbl[k].acc) push(tbl[k].op, tbl[k].dest, tbl[k].fa, tbl[k].fb);
      cyc(tbl[k].iv, tbl[k].op, tbl[k].dest, tbl[k].q1, tbl[k].v1, tbl[k].q2, tbl[k].v2,
          tbl[k].ctag, tbl[k].cdata, tbl[k].drdy);
      outs($sformatf("vec%0d", k), tbl[k].cnt, tbl[k].irdy, tbl[k].dv, tbl[k].da, tbl[k].db, tbl[k].dt);
    end

    // Issue + dispatch at COUNT=2: new entry lands at index 2, not the freed index 0
    push(4'h1, 4'h1, 32'h10, 32'h20);
    push(4'h4, 4'h4, 32'h50, 32'h60);
    push(4'h3, 4'h3, 32'h30, 32'h40);
    push(4'h2, 4'h2, 32'h99, 32'h99);
    cyc(1'b1, 4'h1, 4'h1, 4'h0, 32'h10, 4'h0, 32'h20, 4'h0, 32'h0, 1'b0);
    outs("sa1", 3'd1, 1'b1, 1'b1, 32'h10, 32'h20, 4'h1);
    cyc(1'b1, 4'h2, 4'h2, 4'h9, 32'hDEAD_0001, 4'h9, 32'hDEAD_0002, 4'h0, 32'h0, 1'b0);
    outs("sa2", 3'd2, 1'b1, 1'b1, 32'h10, 32'h20, 4'h1);
    cyc(1'b1, 4'h3, 4'h3, 4'h0, 32'h30, 4'h0, 32'h40, 4'h0, 32'h0, 1'b1);
    outs("sa3", 3'd2, 1'b1, 1'b1, 32'h30, 32'h40, 4'h3);
    cyc(1'b1, 4'h4, 4'h4, 4'h0, 32'h50, 4'h0, 32'h60, 4'h0, 32'h0, 1'b0);
    outs("sa4", 3'd3, 1'b1, 1'b1, 32'h50, 32'h60, 4'h4);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b1);
    outs("sa5", 3'd2, 1'b1, 1'b1, 32'h30, 32'h40, 4'h3);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b1);
    outs("sa6", 3'd1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h9, 32'h99, 1'b0);
    outs("sa7", 3'd1, 1'b1, 1'b1, 32'h99, 32'h99, 4'h2);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b1);
    outs("sa8", 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

    // Full + dispatch: held issue is refused that cycle and accepted the next
    for (int k = 1; k <= 4; k++) push(4'(k), 4'(k), 32'(k * 256), 32'(k));
    sb_q.insert(2, '{4'h5, 4'h5, 32'h500, 32'h5});
    for (int k = 1; k <= 4; k++)
      cyc(1'b1, 4'(k), 4'(k), 4'h0, 32'(k * 256), 4'h0, 32'(k), 4'h0, 32'h0, 1'b0);
    outs("sb4", 3'd4, 1'b0, 1'b1, 32'h100, 32'h1, 4'h1);
    cyc(1'b1, 4'h5, 4'h5, 4'h0, 32'h500, 4'h0, 32'h5, 4'h0, 32'h0, 1'b1);
    outs("sb5", 3'd3, 1'b1, 1'b1, 32'h200, 32'h2, 4'h2);
    cyc(1'b1, 4'h5, 4'h5, 4'h0, 32'h500, 4'h0, 32'h5, 4'h0, 32'h0, 1'b1);
    outs("sb6", 3'd3, 1'b1, 1'b1, 32'h500, 32'h5, 4'h5);
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b1);
    outs("sb9", 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

    // Asynchronous reset between edges with two entries held
    cyc(1'b1, 4'h1, 4'h1, 4'h0, 32'h1, 4'h0, 32'h2, 4'h0, 32'h0, 1'b0);
    cyc(1'b1, 4'h2, 4'h2, 4'h0, 32'h3, 4'h0, 32'h4, 4'h0, 32'h0, 1'b0);
    outs("sc_pre", 3'd2, 1'b1, 1'b1, 32'h1, 32'h2, 4'h1);
    ISSUE_VALID = 1'b0;
    #2 RST = 1'b1;
    #1 outs("sc_rst", 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    #2 RST = 1'b0;
    @(posedge CLK);
    #1 outs("sc_post", 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

    chk("sb_left", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
